// File: rtl/timer_pkg.sv
// Shared timer definitions: opcode and sub-op encodings, ALU control codes
// for the timer writes, the state type and the decoded command payload.
// The control unit and timer_unit both import this package.
package timer_pkg;

    localparam logic [6:0] TIM_OPCODE  = 7'b0100101;
    localparam logic [2:0] F3_ENABLE   = 3'b000;
    localparam logic [2:0] F3_DISABLE  = 3'b111;
    localparam logic [5:0] ALU_TIM_PSC = 6'b100001;
    localparam logic [5:0] ALU_TIM_ARR = 6'b100010;

    localparam int unsigned OPND_W = 32;

    typedef enum logic {
        IDLE,
        RUN
    } tim_state_t;

    // Decoded timer command for the current execute cycle
    typedef struct packed {
        logic              start;
        logic              stop;
        logic              wr_psc;
        logic              wr_arr;
        logic [OPND_W-1:0] operand;
    } tim_cmd_t;

    // ENABLE/DISABLE own their funct3 codes; every other code is a write
    // candidate that additionally needs timer_en and a matching alu_cntrl.
    function automatic tim_cmd_t decode_cmd(
        input logic              valid,
        input logic [2:0]        f3,
        input logic              ten,
        input logic              read_reg,
        input logic [5:0]        alu,
        input logic [OPND_W-1:0] rs1,
        input logic [OPND_W-1:0] imm_v
    );
        tim_cmd_t cmd;
        logic     is_wr;
        cmd.start   = valid && (f3 == F3_ENABLE);
        cmd.stop    = valid && (f3 == F3_DISABLE);
        is_wr       = valid && (f3 != F3_ENABLE) && (f3 != F3_DISABLE) && ten;
        cmd.wr_psc  = is_wr && (alu == ALU_TIM_PSC);
        cmd.wr_arr  = is_wr && (alu == ALU_TIM_ARR);
        cmd.operand = read_reg ? rs1 : imm_v;
        return cmd;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler divider: counts 0..psc_max while enabled and flags a tick on the
// cycle it wraps. clear forces the count to zero and suppresses that cycle's
// tick.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous clear of the divider
//   enable       : count this cycle
//   psc_max      : terminal count (active prescaler value)
//   tick_c       : combinational wrap indication for the current cycle
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned PSC_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [PSC_W-1:0] psc_max,
    output logic             tick_c
);

    logic [PSC_W-1:0] psc_cnt;
    logic             at_max;

    assign at_max = (psc_cnt == psc_max);
    assign tick_c = enable && !clear && at_max;

    // Divider register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc_cnt <= '0;
        end else if (clear) begin
            psc_cnt <= '0;
        end else if (enable) begin
            if (at_max) begin
                psc_cnt <= '0;
            end else begin
                psc_cnt <= psc_cnt + PSC_W'(1);
            end
        end
    end

endmodule

// File: rtl/timer_unit.sv
// Timer execution unit for the custom timer opcode: ENABLE/DISABLE and
// shadowed PSC/ARR writes, a prescaled up-counter, a sticky overflow flag and
// a one-cycle interrupt pulse on every update event.
//   clk, reset_n   : clock, asynchronous active-low reset
//   tim_valid      : timer opcode in execute, qualifies all command inputs
//   funct3         : 000 ENABLE, 111 DISABLE, others are writes
//   timer_en       : write permission from the control unit
//   timer_read_reg : operand select, 1 = rs1_data, 0 = imm
//   alu_cntrl      : write target (PSC or ARR)
//   rs1_data, imm  : operand sources
//   ovf_clr        : clears tim_ovf (an update in the same cycle wins)
//   tim_cnt        : counter value
//   tim_running    : high while in RUN
//   tim_ovf        : sticky overflow flag
//   tim_irq        : one-cycle pulse per update event
module timer_unit
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PSC_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tim_valid,
    input  logic [2:0]       funct3,
    input  logic             timer_en,
    input  logic             timer_read_reg,
    input  logic [5:0]       alu_cntrl,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      imm,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] tim_cnt,
    output logic             tim_running,
    output logic             tim_ovf,
    output logic             tim_irq
);

    tim_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [PSC_W-1:0] psc_active, psc_active_nxt;
    logic [PSC_W-1:0] psc_shadow, psc_shadow_nxt;
    logic [CNT_W-1:0] arr_active, arr_active_nxt;
    logic [CNT_W-1:0] arr_shadow, arr_shadow_nxt;
    logic             pend, pend_nxt;
    logic             ovf_nxt;
    logic             irq_nxt;
    logic             running_nxt;

    tim_cmd_t         cmd;
    logic [PSC_W-1:0] psc_wr;
    logic [CNT_W-1:0] arr_wr;
    logic             psc_clear;
    logic             psc_enable;
    logic             tick_c;
    logic             upd_evt;

    assign cmd    = decode_cmd(tim_valid, funct3, timer_en, timer_read_reg,
                               alu_cntrl, rs1_data, imm);
    assign psc_wr = PSC_W'(cmd.operand);
    assign arr_wr = CNT_W'(cmd.operand);

    // Divider restarts on ENABLE from IDLE and on DISABLE; a DISABLE drops
    // any tick of that cycle.
    assign psc_enable = (state == RUN);
    assign psc_clear  = ((state == IDLE) && cmd.start) ||
                        ((state == RUN)  && cmd.stop);

    timer_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (psc_clear),
        .enable  (psc_enable),
        .psc_max (psc_active),
        .tick_c  (tick_c)
    );

    // Next-state and register update logic
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = tim_cnt;
        psc_active_nxt = psc_active;
        psc_shadow_nxt = psc_shadow;
        arr_active_nxt = arr_active;
        arr_shadow_nxt = arr_shadow;
        pend_nxt       = pend;
        irq_nxt        = 1'b0;
        upd_evt        = 1'b0;

        case (state)
            IDLE: begin
                if (cmd.start) begin
                    state_nxt      = RUN;
                    cnt_nxt        = '0;
                    psc_active_nxt = psc_shadow;
                    arr_active_nxt = arr_shadow;
                    pend_nxt       = 1'b0;
                end
                // Stopped timer: writes take effect immediately
                if (cmd.wr_psc) begin
                    psc_shadow_nxt = psc_wr;
                    psc_active_nxt = psc_wr;
                end
                if (cmd.wr_arr) begin
                    arr_shadow_nxt = arr_wr;
                    arr_active_nxt = arr_wr;
                end
            end
            RUN: begin
                if (cmd.stop) begin
                    state_nxt = IDLE;
                end else if (tick_c) begin
                    if (tim_cnt == arr_active) begin
                        upd_evt = 1'b1;
                        cnt_nxt = '0;
                        irq_nxt = 1'b1;
                        if (pend) begin
                            psc_active_nxt = psc_shadow;
                            arr_active_nxt = arr_shadow;
                            pend_nxt       = 1'b0;
                        end
                    end else begin
                        cnt_nxt = tim_cnt + CNT_W'(1);
                    end
                end
                // Running timer: writes go to the shadow only. A write that
                // coincides with an update re-arms pend after the copy above.
                if (cmd.wr_psc) begin
                    psc_shadow_nxt = psc_wr;
                    pend_nxt       = 1'b1;
                end
                if (cmd.wr_arr) begin
                    arr_shadow_nxt = arr_wr;
                    pend_nxt       = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Set has priority over clear
        if (upd_evt) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = tim_ovf;
        end

        running_nxt = (state_nxt == RUN);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tim_cnt     <= '0;
            psc_active  <= '0;
            psc_shadow  <= '0;
            arr_active  <= '1;
            arr_shadow  <= '1;
            pend        <= 1'b0;
            tim_ovf     <= 1'b0;
            tim_irq     <= 1'b0;
            tim_running <= 1'b0;
        end else begin
            state       <= state_nxt;
            tim_cnt     <= cnt_nxt;
            psc_active  <= psc_active_nxt;
            psc_shadow  <= psc_shadow_nxt;
            arr_active  <= arr_active_nxt;
            arr_shadow  <= arr_shadow_nxt;
            pend        <= pend_nxt;
            tim_ovf     <= ovf_nxt;
            tim_irq     <= irq_nxt;
            tim_running <= running_nxt;
        end
    end

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: a table of directed vectors, hand-built
// corner sequences and a randomized phase, all checked against a phase-based
// reference model.
module tb_timer_unit;
    import timer_pkg::*;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned PSC_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             tim_valid;
    logic [2:0]       funct3;
    logic             timer_en;
    logic             timer_read_reg;
    logic [5:0]       alu_cntrl;
    logic [31:0]      rs1_data;
    logic [31:0]      imm;
    logic             ovf_clr;
    logic [CNT_W-1:0] tim_cnt;
    logic             tim_running;
    logic             tim_ovf;
    logic             tim_irq;

    always #5 clk = ~clk;

    timer_unit #(
        .CNT_W (CNT_W),
        .PSC_W (PSC_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tim_valid      (tim_valid),
        .funct3         (funct3),
        .timer_en       (timer_en),
        .timer_read_reg (timer_read_reg),
        .alu_cntrl      (alu_cntrl),
        .rs1_data       (rs1_data),
        .imm            (imm),
        .ovf_clr        (ovf_clr),
        .tim_cnt        (tim_cnt),
        .tim_running    (tim_running),
        .tim_ovf        (tim_ovf),
        .tim_irq        (tim_irq)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position inside the current update period, period
    // length (psc+1)*(arr+1), counter = position / (psc+1).
    bit               m_run;
    longint unsigned  m_t;
    logic [CNT_W-1:0] m_cnt;
    logic [PSC_W-1:0] m_pa, m_ps;
    logic [CNT_W-1:0] m_aa, m_as;
    bit               m_pend, m_ovf, m_irq;

    function automatic longint unsigned m_period();
        return (64'(m_pa) + 64'd1) * (64'(m_aa) + 64'd1);
    endfunction

    function automatic bit m_upd_next();
        return m_run && ((m_t + 64'd1) == m_period());
    endfunction

    task automatic model_reset();
        m_run = 0; m_t = 0; m_cnt = '0;
        m_pa = '0; m_ps = '0; m_aa = '1; m_as = '1;
        m_pend = 0; m_ovf = 0; m_irq = 0;
    endtask

    task automatic model_step();
        bit          en, dis, wp, wa, upd;
        logic [31:0] op;
        en  = tim_valid && (funct3 == 3'b000);
        dis = tim_valid && (funct3 == 3'b111);
        wp  = tim_valid && !en && !dis && timer_en && (alu_cntrl == 6'b100001);
        wa  = tim_valid && !en && !dis && timer_en && (alu_cntrl == 6'b100010);
        op  = timer_read_reg ? rs1_data : imm;
        upd = 0;
        if (!m_run) begin
            if (en) begin
                m_run = 1; m_t = 0; m_cnt = '0;
                m_pa = m_ps; m_aa = m_as; m_pend = 0;
            end
            if (wp) begin m_ps = op[PSC_W-1:0]; m_pa = m_ps; end
            if (wa) begin m_as = op; m_aa = op; end
        end else begin
            if (dis) begin
                m_run = 0;
            end else begin
                m_t = m_t + 64'd1;
                if (m_t == m_period()) begin
                    upd = 1;
                    m_t = 0;
                    if (m_pend) begin m_pa = m_ps; m_aa = m_as; m_pend = 0; end
                end
                m_cnt = CNT_W'(m_t / (64'(m_pa) + 64'd1));
            end
            if (wp) begin m_ps = op[PSC_W-1:0]; m_pend = 1; end
            if (wa) begin m_as = op; m_pend = 1; end
        end
        m_irq = upd;
        if (upd) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_cnt", 64'(tim_cnt), 64'(m_cnt));
        chk("model_running", 64'(tim_running), 64'(m_run));
        chk("model_ovf", 64'(tim_ovf), 64'(m_ovf));
        chk("model_irq", 64'(tim_irq), 64'(m_irq));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic set_nop();
        tim_valid = 0; funct3 = 3'b001; timer_en = 0; timer_read_reg = 0;
        alu_cntrl = 6'd0; rs1_data = 32'd0; imm = 32'd0; ovf_clr = 0;
    endtask

    // The unselected operand source carries a different value on purpose
    task automatic cmd(input logic [2:0] f3, input logic ten, input logic rr,
                       input logic [5:0] alu, input logic [31:0] op);
        tim_valid = 1; funct3 = f3; timer_en = ten; timer_read_reg = rr;
        alu_cntrl = alu;
        if (rr) begin rs1_data = op; imm = ~op; end
        else begin imm = op; rs1_data = ~op; end
    endtask

    typedef struct {
        logic        valid;
        logic [2:0]  f3;
        logic [5:0]  alu;
        logic [31:0] op;
        logic [31:0] e_cnt;
        logic        e_run;
        logic        e_ovf;
        logic        e_irq;
    } vec_t;

    function automatic vec_t mkv(input logic v, input logic [2:0] f3, input logic [5:0] alu,
                                 input logic [31:0] op, input logic [31:0] c,
                                 input logic r, input logic o, input logic q);
        vec_t x;
        x.valid = v; x.f3 = f3; x.alu = alu; x.op = op;
        x.e_cnt = c; x.e_run = r; x.e_ovf = o; x.e_irq = q;
        return x;
    endfunction

    vec_t tbl[19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int irq1, irq2, maxc, w, r;

        // PSC=1, ARR=3 in IDLE, ENABLE, then two full periods
        tbl[0]  = mkv(1, 3'b001, 6'b100001, 32'd1, 0, 0, 0, 0);
        tbl[1]  = mkv(1, 3'b010, 6'b100010, 32'd3, 0, 0, 0, 0);
        tbl[2]  = mkv(1, 3'b000, 6'd0,      32'd0, 0, 1, 0, 0);
        tbl[3]  = mkv(0, 3'b001, 6'd0, 0, 0, 1, 0, 0);
        tbl[4]  = mkv(0, 3'b001, 6'd0, 0, 1, 1, 0, 0);
        tbl[5]  = mkv(0, 3'b001, 6'd0, 0, 1, 1, 0, 0);
        tbl[6]  = mkv(0, 3'b001, 6'd0, 0, 2, 1, 0, 0);
        tbl[7]  = mkv(0, 3'b001, 6'd0, 0, 2, 1, 0, 0);
        tbl[8]  = mkv(0, 3'b001, 6'd0, 0, 3, 1, 0, 0);
        tbl[9]  = mkv(0, 3'b001, 6'd0, 0, 3, 1, 0, 0);
        tbl[10] = mkv(0, 3'b001, 6'd0, 0, 0, 1, 1, 1);
        tbl[11] = mkv(0, 3'b001, 6'd0, 0, 0, 1, 1, 0);
        tbl[12] = mkv(0, 3'b001, 6'd0, 0, 1, 1, 1, 0);
        tbl[13] = mkv(0, 3'b001, 6'd0, 0, 1, 1, 1, 0);
        tbl[14] = mkv(0, 3'b001, 6'd0, 0, 2, 1, 1, 0);
        tbl[15] = mkv(0, 3'b001, 6'd0, 0, 2, 1, 1, 0);
        tbl[16] = mkv(0, 3'b001, 6'd0, 0, 3, 1, 1, 0);
        tbl[17] = mkv(0, 3'b001, 6'd0, 0, 3, 1, 1, 0);
        tbl[18] = mkv(0, 3'b001, 6'd0, 0, 0, 1, 1, 1);

        // Reset and idle
        set_nop();
        reset_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", 64'(tim_cnt), 64'd0);
        chk("rst_running", 64'(tim_running), 64'd0);
        chk("rst_ovf", 64'(tim_ovf), 64'd0);
        chk("rst_irq", 64'(tim_irq), 64'd0);
        reset_n = 1;
        repeat (10) cycle();

        // Directed table
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].valid) cmd(tbl[i].f3, 1'b1, 1'b0, tbl[i].alu, tbl[i].op);
            else set_nop();
            cycle();
            chk($sformatf("tbl%0d_cnt", i), 64'(tim_cnt), 64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_running", i), 64'(tim_running), 64'(tbl[i].e_run));
            chk($sformatf("tbl%0d_ovf", i), 64'(tim_ovf), 64'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_irq", i), 64'(tim_irq), 64'(tbl[i].e_irq));
        end

        // ARR=7 via rs1 while running: current period still wraps at 3
        cmd(3'b010, 1'b1, 1'b1, 6'b100010, 32'd7);
        cycle();
        set_nop();
        irq1 = -1; irq2 = -1; maxc = 0;
        for (int i = 2; i <= 30; i++) begin
            cycle();
            if (tim_irq) begin
                if (irq1 < 0) irq1 = i;
                else if (irq2 < 0) irq2 = i;
            end
            if (irq1 > 0 && irq2 < 0 && int'(tim_cnt) > maxc) maxc = int'(tim_cnt);
        end
        chk("shadow_first_wrap", 64'(irq1), 64'd8);
        chk("shadow_second_wrap", 64'(irq2), 64'd24);
        chk("shadow_new_max", 64'(maxc), 64'd7);

        // DISABLE at count 2, idle, re-ENABLE
        for (w = 0; w < 40 && tim_cnt != 2; w++) cycle();
        chk("wait_cnt2", 64'(tim_cnt), 64'd2);
        cmd(3'b111, 1'b0, 1'b0, 6'd0, 32'd0);
        cycle();
        set_nop();
        chk("dis_cnt", 64'(tim_cnt), 64'd2);
        chk("dis_running", 64'(tim_running), 64'd0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_hold_cnt", 64'(tim_cnt), 64'd2);
        end
        cmd(3'b000, 1'b0, 1'b0, 6'd0, 32'd0);
        cycle();
        set_nop();
        chk("reen_cnt", 64'(tim_cnt), 64'd0);
        chk("reen_running", 64'(tim_running), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("reen_no_irq", 64'(tim_irq), 64'd0);
        end

        // ovf_clr coincident with an update, then one cycle later
        ovf_clr = 1;
        cycle();
        ovf_clr = 0;
        chk("ovf_cleared", 64'(tim_ovf), 64'd0);
        for (w = 0; w < 64 && !m_upd_next(); w++) cycle();
        chk("wait_update", 64'(m_upd_next()), 64'd1);
        ovf_clr = 1;
        cycle();
        chk("clr_vs_set_ovf", 64'(tim_ovf), 64'd1);
        chk("clr_vs_set_irq", 64'(tim_irq), 64'd1);
        cycle();
        ovf_clr = 0;
        chk("clr_after_ovf", 64'(tim_ovf), 64'd0);

        // PSC=0, ARR=0: update every cycle with counter pinned at 0
        cmd(3'b111, 1'b0, 1'b0, 6'd0, 32'd0); cycle();
        cmd(3'b001, 1'b1, 1'b0, 6'b100001, 32'd0); cycle();
        cmd(3'b010, 1'b1, 1'b0, 6'b100010, 32'd0); cycle();
        cmd(3'b000, 1'b0, 1'b0, 6'd0, 32'd0); cycle();
        set_nop();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("fast_irq", 64'(tim_irq), 64'd1);
            chk("fast_cnt", 64'(tim_cnt), 64'd0);
        end

        // Asynchronous reset mid-run
        #2 reset_n = 0;
        model_reset();
        #1;
        chk("arst_cnt", 64'(tim_cnt), 64'd0);
        chk("arst_running", 64'(tim_running), 64'd0);
        chk("arst_ovf", 64'(tim_ovf), 64'd0);
        chk("arst_irq", 64'(tim_irq), 64'd0);
        @(negedge clk);
        reset_n = 1;
        cmd(3'b000, 1'b0, 1'b0, 6'd0, 32'd0);
        cycle();
        set_nop();
        repeat (10) cycle();
        chk("arr_ones_cnt", 64'(tim_cnt), 64'd10);
        chk("arr_ones_irq", 64'(tim_irq), 64'd0);

        // Second asynchronous reset with a nonzero count
        #2 reset_n = 0;
        model_reset();
        #1;
        chk("arst2_cnt", 64'(tim_cnt), 64'd0);
        chk("arst2_running", 64'(tim_running), 64'd0);
        @(negedge clk);
        reset_n = 1;

        // Randomized phase against the model
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            tim_valid = (r < 40);
            case ($urandom_range(0, 7))
                0: funct3 = 3'b000;
                1: funct3 = 3'b111;
                default: funct3 = 3'($urandom_range(1, 6));
            endcase
            timer_en = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 4))
                0, 1: alu_cntrl = 6'b100001;
                2, 3: alu_cntrl = 6'b100010;
                default: alu_cntrl = 6'($urandom);
            endcase
            timer_read_reg = 1'($urandom_range(0, 1));
            rs1_data = 32'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0) rs1_data[31:16] = 16'($urandom);
            imm = 32'($urandom_range(0, 4));
            ovf_clr = ($urandom_range(0, 9) == 0);
            cycle();
        end
        set_nop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
